// File: rtl/maxpool_2x2.sv
// maxpool_2x2: streaming 2x2 / stride-2 signed max-pooling stage.
// Pixels arrive in raster order. Even rows fill a half-width line buffer
// with horizontal pair maxima. Odd rows combine their own pair maximum with
// the buffered value and emit one pooled pixel per 2x2 window.
// Optional feature macro: MAXPOOL_NEG_CLAMP_EN clamps negative inputs to 0
// before they are used.
module maxpool_2x2 #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_last
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int HALF  = IMG_W / 2;
    localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    typedef enum logic {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [COL_W-1:0]               col_q, col_d;
    logic [ROW_W-1:0]               row_q, row_d;
    logic signed [DATA_WIDTH-1:0]   pair_q, pair_d;
    logic                           out_valid_q, out_valid_d;
    logic signed [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                           out_last_q, out_last_d;

    logic signed [DATA_WIDTH-1:0]   line_buf [HALF];
    logic [IDX_W-1:0]               lb_idx;
    logic                           lb_we;
    logic signed [DATA_WIDTH-1:0]   lb_rdata;

    logic signed [DATA_WIDTH-1:0]   pix;
    logic signed [DATA_WIDTH-1:0]   pair_max;
    logic signed [DATA_WIDTH-1:0]   window_max;

    // Input conditioning: optionally rectify activations that were not
    // already passed through ReLU upstream.
    always_comb begin
`ifdef MAXPOOL_NEG_CLAMP_EN
        pix = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
        pix = in_data;
`endif
    end

    // Horizontal pair maximum and full window maximum, both signed.
    always_comb begin
        lb_idx     = IDX_W'(col_q >> 1);
        lb_rdata   = line_buf[lb_idx];
        pair_max   = (pix > pair_q) ? pix : pair_q;
        window_max = (lb_rdata > pair_max) ? lb_rdata : pair_max;
    end

    // Next-state logic: counters, row-parity FSM, pair capture and output.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        pair_d      = pair_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = out_data_q;
        lb_we       = 1'b0;

        if (in_valid) begin
            if (col_q == COL_LAST) begin
                col_d   = '0;
                row_d   = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                state_d = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
            end else begin
                col_d = col_q + COL_W'(1);
            end

            if (!col_q[0]) begin
                pair_d = pix;
            end else begin
                case (state_q)
                    EVEN_ROW: lb_we = 1'b1;
                    ODD_ROW: begin
                        out_valid_d = 1'b1;
                        out_data_d  = window_max;
                        out_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
                    end
                    default: lb_we = 1'b0;
                endcase
            end
        end
    end

    // State registers with asynchronous clear; a reset discards any partial window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EVEN_ROW;
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Line buffer of even-row pair maxima; left unreset since every entry is
    // rewritten in the even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            line_buf[lb_idx] <= pair_max;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool_2x2.sv
// tb_maxpool_2x2: scoreboard bench for maxpool_2x2 on a 4x4 frame.
// Stimulus pushes hand-computed pooled values; a monitor pops and compares.
module tb_maxpool_2x2;

   localparam int DW = 8;
   localparam int W  = 4;
   localparam int H  = 4;

   typedef struct {
      int data;
      int last;
   } exp_s;

   logic                 clock;
   logic                 reset;
   logic                 inValid;
   logic signed [DW-1:0] inData;
   logic                 outValid;
   logic signed [DW-1:0] outData;
   logic                 outLast;

   exp_s expQ[$];
   int   checks;
   int   errors;

   logic signed [DW-1:0] frameA [16];
   logic signed [DW-1:0] frameB [16];
   logic signed [DW-1:0] frameS [16];
   int                   expA [4];
   int                   expB [4];
   int                   expS [4];

   maxpool_2x2 #(
      .DATA_WIDTH(DW),
      .IMG_W(W),
      .IMG_H(H)
   ) dut (
      .clk(clock),
      .rst(reset),
      .in_valid(inValid),
      .in_data(inData),
      .out_valid(outValid),
      .out_data(outData),
      .out_last(outLast)
   );

   // Free-running clock, 10 ns period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drives one valid pixel, accepted at the next rising edge.
   task automatic applyStimulus(input logic signed [DW-1:0] val);
      inValid = 1'b1;
      inData  = val;
      @(posedge clock);
      #1;
      inValid = 1'b0;
   endtask

   task automatic applyIdle();
      inValid = 1'b0;
      @(posedge clock);
      #1;
   endtask

   // Sends the first 'count' pixels of a 4x4 frame, pushing the expected pooled
   // value whenever the beat completes a window (indices 5, 7, 13, 15).
   task automatic sendFrame(input logic signed [DW-1:0] pix [16], input int expVal [4],
                            input bit gaps, input int count);
      exp_s e;
      for (int i = 0; i < count; i++) begin
         if (i == 5 || i == 7 || i == 13 || i == 15) begin
            e.data = (i == 5) ? expVal[0] : (i == 7) ? expVal[1] : (i == 13) ? expVal[2] : expVal[3];
            e.last = (i == 15) ? 1 : 0;
            expQ.push_back(e);
         end
         applyStimulus(pix[i]);
         if (gaps) applyIdle();
      end
   endtask

   // Bounded wait for the scoreboard to empty.
   task automatic waitDrain(input string name);
      repeat (3) @(posedge clock);
      for (int n = 0; n < 20 && expQ.size() != 0; n++) @(posedge clock);
      #1;
      checkOutput(name, expQ.size(), 0);
   endtask

   // Monitor: compare every presented output against the scoreboard head.
   always @(negedge clock) begin
      exp_s e;
      if (!reset && outValid) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: got data=%0d last=%0b, expected no output",
                     outData, outLast);
         end else begin
            e = expQ.pop_front();
            checkOutput("pooled_data", int'(outData), e.data);
            checkOutput("pooled_last", int'(outLast), e.last);
         end
      end
   end

   initial begin
      checks  = 0;
      errors  = 0;
      inValid = 1'b0;
      inData  = '0;
      reset   = 1'b1;

      for (int i = 0; i < 16; i++) begin
         frameA[i] = DW'(i + 1);
         frameB[i] = DW'(i + 21);
      end
      expA = '{6, 8, 14, 16};
      expB = '{26, 28, 34, 36};

      frameS = '{-8'sd128, 8'sd127, -8'sd5, -8'sd5,
                 -8'sd1,   8'sd0,   -8'sd5, -8'sd5,
                 -8'sd100, -8'sd50, 8'sd3,  -8'sd7,
                 -8'sd60,  -8'sd20, 8'sd2,  -8'sd9};
`ifdef MAXPOOL_NEG_CLAMP_EN
      expS = '{127, 0, 0, 3};
`else
      expS = '{127, -5, -20, 3};
`endif

      $display("[TB] reset state");
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset_out_valid", int'(outValid), 0);
      checkOutput("reset_out_data", int'(outData), 0);
      checkOutput("reset_out_last", int'(outLast), 0);
      reset = 1'b0;
      @(posedge clock);
      #1;

      $display("[TB] frame 1..16 back-to-back beats");
      sendFrame(frameA, expA, 1'b0, 16);
      waitDrain("drain_frame_a");

      $display("[TB] frame 1..16 with idle gaps");
      sendFrame(frameA, expA, 1'b1, 16);
      waitDrain("drain_gapped");

      $display("[TB] two consecutive frames");
      sendFrame(frameA, expA, 1'b0, 16);
      sendFrame(frameB, expB, 1'b0, 16);
      waitDrain("drain_two_frames");

      $display("[TB] signed extremes frame");
      sendFrame(frameS, expS, 1'b0, 16);
      waitDrain("drain_signed");

      $display("[TB] reset mid-frame");
      sendFrame(frameA, expA, 1'b0, 9);
      waitDrain("drain_partial");
      reset = 1'b1;
      #1;
      checkOutput("midreset_out_valid", int'(outValid), 0);
      checkOutput("midreset_out_data", int'(outData), 0);
      checkOutput("midreset_out_last", int'(outLast), 0);
      repeat (2) @(posedge clock);
      #1;
      checkOutput("midreset_hold_data", int'(outData), 0);
      reset = 1'b0;
      @(posedge clock);
      #1;
      sendFrame(frameA, expA, 1'b0, 16);
      waitDrain("drain_after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
